// File: rtl/mask_unit_read_sequencer.sv
// Mask-unit gather sequencer: turns one vector read command into 4-element
// groups of crossbar reads and hands back each group zero-extended.
// Ports: cmd_* command handshake and fields; readReq_N_* crossbar requester
// N (0..3); readResp_* returning lane word tagged by writeIndex; out_* one
// completed group (data, element mask, last flag); busy while not idle.

module mask_unit_read_sequencer #(
    parameter int ELEM_W   = 10,
    parameter int VS_W     = 5,
    parameter int OFFSET_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [VS_W-1:0]     cmd_bits_vs,
    input  logic [ELEM_W-1:0]   cmd_bits_startIndex,
    input  logic [ELEM_W:0]     cmd_bits_count,
    input  logic [1:0]          cmd_bits_eew,
    output logic                readReq_0_valid,
    input  logic                readReq_0_ready,
    output logic [VS_W-1:0]     readReq_0_bits_vs,
    output logic [OFFSET_W-1:0] readReq_0_bits_offset,
    output logic [1:0]          readReq_0_bits_readLane,
    output logic [1:0]          readReq_0_bits_dataOffset,
    output logic                readReq_1_valid,
    input  logic                readReq_1_ready,
    output logic [VS_W-1:0]     readReq_1_bits_vs,
    output logic [OFFSET_W-1:0] readReq_1_bits_offset,
    output logic [1:0]          readReq_1_bits_readLane,
    output logic [1:0]          readReq_1_bits_dataOffset,
    output logic                readReq_2_valid,
    input  logic                readReq_2_ready,
    output logic [VS_W-1:0]     readReq_2_bits_vs,
    output logic [OFFSET_W-1:0] readReq_2_bits_offset,
    output logic [1:0]          readReq_2_bits_readLane,
    output logic [1:0]          readReq_2_bits_dataOffset,
    output logic                readReq_3_valid,
    input  logic                readReq_3_ready,
    output logic [VS_W-1:0]     readReq_3_bits_vs,
    output logic [OFFSET_W-1:0] readReq_3_bits_offset,
    output logic [1:0]          readReq_3_bits_readLane,
    output logic [1:0]          readReq_3_bits_dataOffset,
    input  logic                readResp_valid,
    input  logic [1:0]          readResp_bits_writeIndex,
    input  logic [31:0]         readResp_bits_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_bits_data,
    output logic [3:0]          out_bits_mask,
    output logic                out_bits_last,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } seqState_t;

    seqState_t state;

    logic [VS_W-1:0]     vsReg;
    logic [1:0]          eewReg;
    logic [ELEM_W:0]     remaining;
    logic [ELEM_W-1:0]   cursor;
    logic [3:0]          pend;
    logic [3:0]          outstanding;
    logic [3:0]          done;
    logic [3:0]          maskReg;
    logic                lastReg;
    logic                outValidReg;
    logic [VS_W-1:0]     reqVs   [4];
    logic [OFFSET_W-1:0] reqOff  [4];
    logic [1:0]          reqLane [4];
    logic [1:0]          reqDOff [4];
    logic [31:0]         dataReg [4];

    logic [3:0]          reqReady;
    logic [3:0]          reqFire;
    logic [3:0]          respHit;
    logic [3:0]          doneNext;
    logic                outFire;
    logic                doLoad;
    logic [ELEM_W:0]     groupSize;
    logic [VS_W-1:0]     ldVs;
    logic [1:0]          ldEew;
    logic [ELEM_W-1:0]   ldCursor;
    logic [ELEM_W:0]     ldRemain;
    logic [3:0]          ldMask;
    logic                ldLast;
    logic [ELEM_W-1:0]   ldElem  [4];
    logic [ELEM_W-1:0]   ldWord  [4];
    logic [VS_W-1:0]     ldReqVs [4];
    logic [OFFSET_W-1:0] ldReqOff[4];
    logic [1:0]          ldReqLane[4];
    logic [1:0]          ldReqDOff[4];
    logic [31:0]         widthMask;
    logic [31:0]         respShift[4];
    logic [31:0]         respExt [4];

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign reqReady  = {readReq_3_ready, readReq_2_ready,
                        readReq_1_ready, readReq_0_ready};
    assign reqFire   = pend & reqReady;
    assign doneNext  = done | respHit;
    assign outFire   = outValidReg && out_ready;
    assign groupSize = (remaining > (ELEM_W+1)'(4)) ?
                       (ELEM_W+1)'(4) : remaining;

    // A response counts only for a slot whose request already went out
    // on an earlier edge; anything else is dropped.
    always_comb begin
        respHit = '0;
        for (int k = 0; k < 4; k++) begin
            respHit[k] = readResp_valid && outstanding[k] &&
                         (readResp_bits_writeIndex == 2'(k));
        end
    end

    // Group load source: the new command in IDLE, the following group
    // when draining.
    always_comb begin
        if (state == IDLE) begin
            ldVs     = cmd_bits_vs;
            ldEew    = cmd_bits_eew;
            ldCursor = cmd_bits_startIndex;
            ldRemain = cmd_bits_count;
        end else begin
            ldVs     = vsReg;
            ldEew    = eewReg;
            ldCursor = cursor + ELEM_W'(4);
            ldRemain = remaining - groupSize;
        end
    end

    assign doLoad = (state == IDLE && cmd_valid &&
                     cmd_bits_count != '0) ||
                    (state == DRAIN && outFire && !lastReg);
    assign ldLast = (ldRemain <= (ELEM_W+1)'(4));

    // word = 32-bit word index of the element; four elements of 8b or
    // two of 16b share one word.
    always_comb begin
        ldMask = '0;
        for (int k = 0; k < 4; k++) begin
            ldElem[k] = ldCursor + ELEM_W'(k);
            ldWord[k] = ldElem[k];
            ldReqDOff[k] = 2'b00;
            unique case (1'b1)
                (ldEew == 2'd0): begin
                    ldWord[k]    = ldElem[k] >> 2;
                    ldReqDOff[k] = ldElem[k][1:0];
                end
                (ldEew == 2'd1): begin
                    ldWord[k]    = ldElem[k] >> 1;
                    ldReqDOff[k] = {ldElem[k][0], 1'b0};
                end
                default: begin
                    ldWord[k]    = ldElem[k];
                    ldReqDOff[k] = 2'b00;
                end
            endcase
            ldReqLane[k] = ldWord[k][1:0];
            ldReqOff[k]  = OFFSET_W'(ldWord[k] >> 2);
            ldReqVs[k]   = ldVs + VS_W'(ldWord[k] >> (OFFSET_W + 2));
            ldMask[k]    = (ldRemain > (ELEM_W+1)'(k));
        end
    end

    always_comb begin
        unique case (1'b1)
            (eewReg == 2'd0): widthMask = 32'h0000_00FF;
            (eewReg == 2'd1): widthMask = 32'h0000_FFFF;
            default:          widthMask = 32'hFFFF_FFFF;
        endcase
        for (int k = 0; k < 4; k++) begin
            respShift[k] = readResp_bits_data >> {reqDOff[k], 3'b000};
            respExt[k]   = respShift[k] & widthMask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            vsReg       <= '0;
            eewReg      <= '0;
            remaining   <= '0;
            cursor      <= '0;
            pend        <= '0;
            outstanding <= '0;
            done        <= '0;
            maskReg     <= '0;
            lastReg     <= 1'b0;
            outValidReg <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                reqVs[k]   <= '0;
                reqOff[k]  <= '0;
                reqLane[k] <= '0;
                reqDOff[k] <= '0;
                dataReg[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (doLoad) state <= BUSY;
                end
                BUSY: begin
                    pend        <= pend & ~reqFire;
                    outstanding <= (outstanding & ~respHit) | reqFire;
                    done        <= doneNext;
                    for (int k = 0; k < 4; k++) begin
                        if (respHit[k]) dataReg[k] <= respExt[k];
                    end
                    if (&doneNext) begin
                        state       <= DRAIN;
                        outValidReg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (outFire) begin
                        outValidReg <= 1'b0;
                        remaining   <= ldRemain;
                        cursor      <= ldCursor;
                        state       <= lastReg ? IDLE : BUSY;
                    end
                end
                default: state <= IDLE;
            endcase
            if (doLoad) begin
                vsReg       <= ldVs;
                eewReg      <= ldEew;
                remaining   <= ldRemain;
                cursor      <= ldCursor;
                pend        <= ldMask;
                outstanding <= '0;
                done        <= ~ldMask;
                maskReg     <= ldMask;
                lastReg     <= ldLast;
                for (int k = 0; k < 4; k++) begin
                    reqVs[k]   <= ldReqVs[k];
                    reqOff[k]  <= ldReqOff[k];
                    reqLane[k] <= ldReqLane[k];
                    reqDOff[k] <= ldReqDOff[k];
                    dataReg[k] <= '0;
                end
            end
        end
    end

    assign readReq_0_valid           = pend[0];
    assign readReq_0_bits_vs         = reqVs[0];
    assign readReq_0_bits_offset     = reqOff[0];
    assign readReq_0_bits_readLane   = reqLane[0];
    assign readReq_0_bits_dataOffset = reqDOff[0];
    assign readReq_1_valid           = pend[1];
    assign readReq_1_bits_vs         = reqVs[1];
    assign readReq_1_bits_offset     = reqOff[1];
    assign readReq_1_bits_readLane   = reqLane[1];
    assign readReq_1_bits_dataOffset = reqDOff[1];
    assign readReq_2_valid           = pend[2];
    assign readReq_2_bits_vs         = reqVs[2];
    assign readReq_2_bits_offset     = reqOff[2];
    assign readReq_2_bits_readLane   = reqLane[2];
    assign readReq_2_bits_dataOffset = reqDOff[2];
    assign readReq_3_valid           = pend[3];
    assign readReq_3_bits_vs         = reqVs[3];
    assign readReq_3_bits_offset     = reqOff[3];
    assign readReq_3_bits_readLane   = reqLane[3];
    assign readReq_3_bits_dataOffset = reqDOff[3];

    assign out_valid     = outValidReg;
    assign out_bits_data = {dataReg[3], dataReg[2], dataReg[1], dataReg[0]};
    assign out_bits_mask = maskReg;
    assign out_bits_last = lastReg;

endmodule

// File: tb/tb_mask_unit_read_sequencer.sv
// Bench for mask_unit_read_sequencer: directed corners plus random
// commands checked against a byte-address model of the register file.

module tb_mask_unit_read_sequencer;

    localparam int ELEM_W   = 10;
    localparam int VS_W     = 5;
    localparam int OFFSET_W = 5;

    logic                clock = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [VS_W-1:0]     cmdVs;
    logic [ELEM_W-1:0]   cmdStart;
    logic [ELEM_W:0]     cmdCount;
    logic [1:0]          cmdEew;
    logic [3:0]          reqValid;
    logic [3:0]          reqReady;
    logic [VS_W-1:0]     reqVs   [4];
    logic [OFFSET_W-1:0] reqOff  [4];
    logic [1:0]          reqLane [4];
    logic [1:0]          reqDOff [4];
    logic                respValid;
    logic [1:0]          respIdx;
    logic [31:0]         respData;
    logic                outValid;
    logic                outReady;
    logic [127:0]        outData;
    logic [3:0]          outMask;
    logic                outLast;
    logic                busy;

    int          nTests = 0;
    int          nFail  = 0;
    int          readyPct, outReadyPct, maxDelay, spurPct;
    int          hold2Left, holdOutLeft;
    logic [31:0] salt;

    always #5 clock = ~clock;

    mask_unit_read_sequencer #(
        .ELEM_W(ELEM_W), .VS_W(VS_W), .OFFSET_W(OFFSET_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_bits_vs(cmdVs), .cmd_bits_startIndex(cmdStart),
        .cmd_bits_count(cmdCount), .cmd_bits_eew(cmdEew),
        .readReq_0_valid(reqValid[0]), .readReq_0_ready(reqReady[0]),
        .readReq_0_bits_vs(reqVs[0]), .readReq_0_bits_offset(reqOff[0]),
        .readReq_0_bits_readLane(reqLane[0]),
        .readReq_0_bits_dataOffset(reqDOff[0]),
        .readReq_1_valid(reqValid[1]), .readReq_1_ready(reqReady[1]),
        .readReq_1_bits_vs(reqVs[1]), .readReq_1_bits_offset(reqOff[1]),
        .readReq_1_bits_readLane(reqLane[1]),
        .readReq_1_bits_dataOffset(reqDOff[1]),
        .readReq_2_valid(reqValid[2]), .readReq_2_ready(reqReady[2]),
        .readReq_2_bits_vs(reqVs[2]), .readReq_2_bits_offset(reqOff[2]),
        .readReq_2_bits_readLane(reqLane[2]),
        .readReq_2_bits_dataOffset(reqDOff[2]),
        .readReq_3_valid(reqValid[3]), .readReq_3_ready(reqReady[3]),
        .readReq_3_bits_vs(reqVs[3]), .readReq_3_bits_offset(reqOff[3]),
        .readReq_3_bits_readLane(reqLane[3]),
        .readReq_3_bits_dataOffset(reqDOff[3]),
        .readResp_valid(respValid), .readResp_bits_writeIndex(respIdx),
        .readResp_bits_data(respData),
        .out_valid(outValid), .out_ready(outReady),
        .out_bits_data(outData), .out_bits_mask(outMask),
        .out_bits_last(outLast), .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-file contents seen by the responder.
    function automatic logic [31:0] memWord(input int vs, input int off,
                                            input int lane);
        return (32'(vs * 131 + off * 7 + lane) * 32'h9E37_79B1) ^ salt;
    endfunction

    // Byte-address model: element e of size s sits at byte e*s.
    task automatic refElem(input int vs0, input int eew, input int e,
                           output int vs, output int off, output int lane,
                           output int boff, output logic [31:0] val);
        int size, ba, w;
        logic [31:0] m;
        size = (eew >= 2) ? 4 : (1 << eew);
        ba   = e * size;
        w    = ba / 4;
        lane = w % 4;
        off  = (w / 4) % (1 << OFFSET_W);
        vs   = (vs0 + w / (4 << OFFSET_W)) % (1 << VS_W);
        boff = ba % 4;
        m    = (size == 4) ? 32'hFFFF_FFFF :
               (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        val  = (memWord(vs, off, lane) >> (8 * boff)) & m;
    endtask

    task automatic runCmd(input int vs0, input int start, input int count,
                          input int eew, input int expLat);
        int rem, cur, neg, gs, grp, pick;
        int st[4];
        int due[4];
        int eVs[4], eOff[4], eLane[4], eBoff[4];
        logic [31:0] eVal[4];
        logic [31:0] rdata[4];
        logic [127:0] expData;
        logic [3:0] expMask;
        bit consumed, allDone, seenOut, r, lastExp;

        @(negedge clock);
        cmd_valid = 1'b1;
        cmdVs     = VS_W'(vs0);
        cmdStart  = ELEM_W'(start);
        cmdCount  = (ELEM_W+1)'(count);
        cmdEew    = 2'(eew);
        reqReady  = '0;
        outReady  = 1'b0;
        respValid = 1'b0;
        check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        @(negedge clock);
        cmd_valid = 1'b0;
        neg = 1;

        if (count == 0) begin
            for (int c = 0; c < 3; c++) begin
                check("zero_busy", 128'(busy), 128'(0));
                check("zero_req", 128'(reqValid), 128'(0));
                check("zero_out", 128'(outValid), 128'(0));
                check("zero_ready", 128'(cmd_ready), 128'(1));
                @(negedge clock);
            end
            return;
        end

        rem = count;
        cur = start;
        grp = 0;
        seenOut = 0;
        while (rem > 0) begin
            gs = (rem < 4) ? rem : 4;
            lastExp = (rem - gs == 0);
            expData = '0;
            expMask = '0;
            for (int k = 0; k < 4; k++) begin
                st[k]  = (k < gs) ? 0 : 2;
                due[k] = 0;
                rdata[k] = '0;
                eVs[k] = 0; eOff[k] = 0; eLane[k] = 0; eBoff[k] = 0;
                eVal[k] = '0;
                if (k < gs) begin
                    refElem(vs0, eew, (cur + k) % (1 << ELEM_W),
                            eVs[k], eOff[k], eLane[k], eBoff[k], eVal[k]);
                    expData[32*k +: 32] = eVal[k];
                    expMask[k] = 1'b1;
                end
            end
            check("grp_start_valid", 128'(reqValid), 128'(expMask));
            consumed = 0;
            for (int c = 0; c < 300 && !consumed; c++) begin
                allDone = 1;
                for (int k = 0; k < 4; k++) begin
                    if (st[k] != 2) allDone = 0;
                    check($sformatf("req%0d_valid", k),
                          128'(reqValid[k]), 128'(st[k] == 0));
                    if (st[k] == 0 && reqValid[k]) begin
                        check($sformatf("req%0d_vs", k),
                              128'(reqVs[k]), 128'(eVs[k]));
                        check($sformatf("req%0d_off", k),
                              128'(reqOff[k]), 128'(eOff[k]));
                        check($sformatf("req%0d_lane", k),
                              128'(reqLane[k]), 128'(eLane[k]));
                        check($sformatf("req%0d_doff", k),
                              128'(reqDOff[k]), 128'(eBoff[k]));
                    end
                end
                check("out_valid", 128'(outValid), 128'(allDone));
                if (outValid) begin
                    check("out_mask", 128'(outMask), 128'(expMask));
                    check("out_last", 128'(outLast), 128'(lastExp));
                    check("out_data", outData, expData);
                    if (!seenOut) begin
                        seenOut = 1;
                        if (grp == 0 && expLat > 0)
                            check("latency", 128'(neg), 128'(expLat));
                    end
                end

                respValid = 1'b0;
                respIdx   = '0;
                respData  = '0;
                pick = -1;
                for (int k = 0; k < 4; k++)
                    if (pick < 0 && st[k] == 1 && due[k] <= neg) pick = k;
                if (pick >= 0) begin
                    respValid = 1'b1;
                    respIdx   = 2'(pick);
                    respData  = rdata[pick];
                    st[pick]  = 2;
                end else if (spurPct > 0 &&
                             int'($urandom_range(99)) < spurPct) begin
                    pick = int'($urandom_range(3));
                    if (st[pick] != 1) begin
                        respValid = 1'b1;
                        respIdx   = 2'(pick);
                        respData  = $urandom;
                    end
                end

                for (int k = 0; k < 4; k++) begin
                    r = int'($urandom_range(99)) < readyPct;
                    if (k == 2 && hold2Left > 0 && st[2] == 0) begin
                        r = 0;
                        hold2Left--;
                    end
                    reqReady[k] = r;
                    if (reqValid[k] && r && st[k] == 0) begin
                        st[k]  = 1;
                        due[k] = neg + 1 + int'($urandom_range(maxDelay));
                        rdata[k] = memWord(int'(reqVs[k]), int'(reqOff[k]),
                                           int'(reqLane[k]));
                    end
                end

                outReady = 1'b0;
                if (outValid) begin
                    r = int'($urandom_range(99)) < outReadyPct;
                    if (holdOutLeft > 0) begin
                        r = 0;
                        holdOutLeft--;
                    end
                    outReady = r;
                    if (r) consumed = 1;
                end
                @(negedge clock);
                neg++;
            end
            if (!consumed) begin
                check("timeout", 128'(0), 128'(1));
                return;
            end
            rem -= gs;
            cur = (cur + 4) % (1 << ELEM_W);
            grp++;
        end
        check("end_busy", 128'(busy), 128'(0));
        check("end_out", 128'(outValid), 128'(0));
        check("end_req", 128'(reqValid), 128'(0));
        check("end_ready", 128'(cmd_ready), 128'(1));
        reqReady  = '0;
        outReady  = 1'b0;
        respValid = 1'b0;
    endtask

    initial begin
        salt      = $urandom;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmdVs     = '0;
        cmdStart  = '0;
        cmdCount  = '0;
        cmdEew    = '0;
        reqReady  = '0;
        respValid = 1'b0;
        respIdx   = '0;
        respData  = '0;
        outReady  = 1'b0;
        hold2Left = 0;
        holdOutLeft = 0;
        @(negedge clock);
        check("rst_ready", 128'(cmd_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_req", 128'(reqValid), 128'(0));
        check("rst_out", 128'(outValid), 128'(0));
        check("rst_data", outData, 128'(0));
        check("rst_mask", 128'(outMask), 128'(0));
        check("rst_last", 128'(outLast), 128'(0));
        @(negedge clock);
        reset = 1'b0;

        readyPct = 100; outReadyPct = 100; maxDelay = 0; spurPct = 0;
        runCmd(3, 0, 4, 2, 6);
        runCmd(3, 0, 1, 2, 3);
        runCmd(9, 5, 6, 0, -1);

        hold2Left = 5;
        runCmd(1, 0, 4, 2, -1);

        holdOutLeft = 4;
        runCmd(2, 16, 8, 1, -1);

        runCmd(4, 7, 0, 0, -1);

        readyPct = 70; maxDelay = 3; spurPct = 100;
        runCmd(5, 100, 7, 0, -1);
        runCmd(6, 1022, 6, 1, -1);
        runCmd(31, 250, 9, 2, -1);
        runCmd(12, 300, 5, 3, -1);

        // Abort with slots 0 and 1 outstanding.
        readyPct = 100; maxDelay = 0; spurPct = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmdVs = 5'd7; cmdStart = '0; cmdCount = 11'd4; cmdEew = 2'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        reqReady  = 4'b0011;
        check("abort_valid", 128'(reqValid), 128'(4'hF));
        @(negedge clock);
        reqReady = '0;
        check("abort_busy_pre", 128'(busy), 128'(1));
        check("abort_valid_pre", 128'(reqValid), 128'(4'b1100));
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_ready", 128'(cmd_ready), 128'(1));
        check("abort_req", 128'(reqValid), 128'(0));
        check("abort_out", 128'(outValid), 128'(0));
        check("abort_mask", 128'(outMask), 128'(0));
        check("abort_last", 128'(outLast), 128'(0));
        check("abort_data", outData, 128'(0));
        @(negedge clock);
        reset     = 1'b0;
        respValid = 1'b1;
        respIdx   = 2'd0;
        respData  = 32'hDEAD_BEEF;
        @(negedge clock);
        respIdx = 2'd1;
        @(negedge clock);
        respValid = 1'b0;
        check("late_busy", 128'(busy), 128'(0));
        check("late_out", 128'(outValid), 128'(0));
        check("late_req", 128'(reqValid), 128'(0));
        check("late_data", outData, 128'(0));
        runCmd(7, 0, 4, 2, 6);

        readyPct = 60; outReadyPct = 60; maxDelay = 3; spurPct = 30;
        for (int i = 0; i < 20; i++) begin
            runCmd(int'($urandom_range(31)), int'($urandom_range(1023)),
                   int'($urandom_range(13)), int'($urandom_range(3)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
